// File: rtl/ps2_keyboard_event_rx.sv
// ps2_keyboard_event_rx
//   PS/2 keyboard receiver producing key events. The raw PS/2 lines are
//   synchronised into the CLOCK_50 domain. The clock line is debounced by a
//   run-length filter. Each 11-bit frame is checked for start, odd parity,
//   stop and inter-bit timeout. E0/F0 prefixes are folded into make/break
//   events, and the events are queued in a first-word-fall-through FIFO.
//
// Ports
//   CLOCK_50    in   system clock (only clock)
//   reset       in   synchronous active-high reset
//   PS2_CLK     in   raw PS/2 clock line (asynchronous)
//   PS2_DAT     in   raw PS/2 data line (asynchronous)
//   ev_valid    out  FIFO head event present
//   ev_ready    in   consumer accepts head event
//   ev_code     out  scan code of head event (0 when empty)
//   ev_break    out  head event is a key release
//   ev_ext      out  head event is an extended key
//   fifo_count  out  number of queued events
//   parity_err  out  pulse: frame dropped, even parity
//   frame_err   out  pulse: frame dropped, bad stop bit or timeout
//   overflow    out  pulse: event dropped, FIFO full
//
// Frame FSM
//   state    | meaning
//   S_IDLE   | line idle, waiting for a start bit (data=0 on strobe)
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the parity bit
//   S_STOP   | checking the stop bit and parity, then back to idle
module ps2_keyboard_event_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               PS2_CLK,
    input  logic               PS2_DAT,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [7:0]         ev_code,
    output logic               ev_break,
    output logic               ev_ext,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               parity_err,
    output logic               frame_err,
    output logic               overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and clock filter
    // ------------------------------------------------------------------
    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  clk_filt, clk_filt_d;
    logic                  strobe;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            filt_sr    <= '1;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_s1     <= PS2_CLK;
            clk_s2     <= clk_s1;
            dat_s1     <= PS2_DAT;
            dat_s2     <= dat_s1;
            filt_sr    <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            // Hysteresis: only a full run of identical samples moves the level.
            if (&filt_sr)
                clk_filt <= 1'b1;
            else if (~|filt_sr)
                clk_filt <= 1'b0;
            clk_filt_d <= clk_filt;
        end
    end

    assign strobe = clk_filt_d & ~clk_filt;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t      state, state_nx;
    logic [TW-1:0] tmr;
    logic        timeout;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt;
    logic        par_q;
    logic        shift_en, clr_cnt, par_ld;
    logic        done_ok, done_par, done_frm;
    logic        byte_done;

    // Down-counter reloaded on every strobe and while idle; reaching zero
    // means TIMEOUT_CYCLES-1 cycles have passed without a strobe.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            tmr <= TMR_LOAD;
        else if (strobe || state == S_IDLE)
            tmr <= TMR_LOAD;
        else if (tmr != '0)
            tmr <= tmr - 1'b1;
    end

    assign timeout = (state != S_IDLE) && !strobe && (tmr == '0);

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (timeout) begin
            state_nx = S_IDLE;
        end else if (strobe) begin
            case (state)
                S_IDLE:   if (!dat_s2) state_nx = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nx = S_PARITY;
                S_PARITY: state_nx = S_STOP;
                S_STOP:   state_nx = S_IDLE;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en = 1'b0;
        clr_cnt  = 1'b0;
        par_ld   = 1'b0;
        done_ok  = 1'b0;
        done_par = 1'b0;
        done_frm = 1'b0;
        if (timeout) begin
            done_frm = 1'b1;
        end else if (strobe) begin
            case (state)
                S_IDLE:   clr_cnt  = 1'b1;
                S_DATA:   shift_en = 1'b1;
                S_PARITY: par_ld   = 1'b1;
                S_STOP: begin
                    // A bad stop bit masks a parity error.
                    if (!dat_s2)
                        done_frm = 1'b1;
                    else if (^{shift_q, par_q})
                        done_ok = 1'b1;
                    else
                        done_par = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            par_q      <= 1'b0;
            byte_done  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (clr_cnt)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)
                shift_q <= {dat_s2, shift_q[7:1]};
            if (par_ld)
                par_q <= dat_s2;
            byte_done  <= done_ok;
            parity_err <= done_par;
            frame_err  <= done_frm;
        end
    end

    // ------------------------------------------------------------------
    // Prefix folding
    // ------------------------------------------------------------------
    logic       brk_pend, ext_pend;
    logic       push_req;
    logic [9:0] push_word;

    always_comb begin
        push_word = {shift_q, brk_pend, ext_pend};
        push_req  = byte_done && (shift_q != 8'hE0) && (shift_q != 8'hF0) &&
                    (shift_q != 8'h00) && (shift_q != 8'hFF);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || parity_err || frame_err) begin
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
        end else if (byte_done) begin
            if (shift_q == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word fall-through, registered head)
    // ------------------------------------------------------------------
    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [FIFO_AW:0]   count_nx;
    logic [9:0]         head_nx;
    logic               pop, do_push, full, ovf_nx;

    assign full    = (fifo_count == DEPTH_C);
    assign pop     = ev_valid && ev_ready;
    assign do_push = push_req && (!full || pop);
    assign ovf_nx  = push_req && full && !pop;

    // The head register is loaded with what the head will be after this
    // edge, so a push into an empty FIFO forwards the incoming word.
    always_comb begin
        count_nx = fifo_count;
        if (do_push && !pop)
            count_nx = fifo_count + 1'b1;
        else if (!do_push && pop)
            count_nx = fifo_count - 1'b1;
        rd_ptr_nx = pop ? rd_ptr + 1'b1 : rd_ptr;
        if (count_nx == '0)
            head_nx = '0;
        else if (do_push && rd_ptr_nx == wr_ptr)
            head_nx = push_word;
        else
            head_nx = mem[rd_ptr_nx];
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ev_valid   <= 1'b0;
            ev_code    <= '0;
            ev_break   <= 1'b0;
            ev_ext     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_ptr_nx;
            fifo_count <= count_nx;
            ev_valid   <= (count_nx != '0);
            {ev_code, ev_break, ev_ext} <= head_nx;
            overflow   <= ovf_nx;
        end
    end

endmodule

// File: doc/ps2_keyboard_event_rx.md
Name: ps2_keyboard_event_rx

Overview:
Parametrised PS/2 keyboard receiver. It replaces the raw scan-code driver and its external read one-shot. It synchronises and filters PS2_CLK/PS2_DAT in the CLOCK_50 domain, checks every frame for start bit, odd parity, stop bit and timeout, and folds E0/F0 prefixes into key events. Events are queued in a first-word-fall-through FIFO with a valid/ready handshake. Downstream letter-decode and LED/encryption logic pop events from it.

Parameters:
FILTER_LEN, 8, number of consecutive identical CLOCK_50 samples required before the filtered PS/2 clock changes level (range 2..32).
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW events.
TIMEOUT_CYCLES, 100000, CLOCK_50 cycles allowed between bit strobes within a frame (2 ms at 50 MHz).

Ports:
CLOCK_50  in  1  system clock, 50 MHz; the only clock.
reset  in  1  synchronous, active-high reset.
PS2_CLK  in  1  raw PS/2 clock line, asynchronous.
PS2_DAT  in  1  raw PS/2 data line, asynchronous.
ev_valid  out  1  FIFO head event present.
ev_ready  in  1  consumer accepts the head event.
ev_code  out  8  scan code of the head event.
ev_break  out  1  head event is a key release (F0 prefix seen).
ev_ext  out  1  head event is an extended key (E0 prefix seen).
fifo_count  out  FIFO_AW+1  number of queued events.
parity_err  out  1  one-cycle pulse: frame discarded because of bad parity.
frame_err  out  1  one-cycle pulse: frame discarded because of bad stop bit or timeout.
overflow  out  1  one-cycle pulse: event dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high):
  - Sync flops, filter register and filtered clock are set to 1 (idle line).
  - FSM goes to IDLE; prefix flags are cleared; FIFO is emptied.
  - All outputs are 0. fifo_count = 0.
  - Reset mid-frame aborts the frame silently: no error pulse, no event.
- Input path:
  - Each line goes through a 2-flop synchroniser.
  - The synchronised clock shifts into a FILTER_LEN-bit register every cycle.
  - Filtered clock goes to 1 only when the register is all ones, and to 0 only when it is all zeros; otherwise it holds.
  - A 1→0 transition of the filtered clock produces a one-cycle strobe. Synchronised data is sampled in that cycle.
- Frame FSM (advances only on strobe, except timeout):
  - IDLE: data=0 → DATA with bit count 0. data=1 → stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: go to IDLE in all cases, with one of three results:
    - stop=1 and the 9 bits have odd parity → byte_done pulse in the next cycle.
    - stop=1 and parity is even → parity_err pulse in the next cycle.
    - stop=0 → frame_err pulse in the next cycle. If parity is also bad, only frame_err is pulsed.
- Timeout:
  - The counter clears on every strobe and while in IDLE.
  - If the FSM is not in IDLE and the counter reaches TIMEOUT_CYCLES-1 → frame_err pulse, FSM goes to IDLE, partial byte is discarded.
- Prefix decode (on byte_done):
  - 0xE0 → ext_pend=1; no event.
  - 0xF0 → brk_pend=1; no event.
  - 0x00 or 0xFF (keyboard error codes) → clear both flags; no event.
  - Any other byte → push {code, brk_pend, ext_pend} in the next cycle, then clear both flags.
  - parity_err or frame_err also clears both flags.
- FIFO:
  - Depth 2**FIFO_AW, first-word fall-through. ev_valid = (fifo_count != 0).
  - ev_code, ev_break and ev_ext show the head entry. They are 0 when the FIFO is empty.
  - Pop when ev_valid && ev_ready.
  - Push when full and no pop in the same cycle → event dropped, overflow pulse, contents unchanged.
  - Push and pop in the same cycle (including when full) → both happen; count is unchanged; order is preserved.
  - Pointers wrap modulo the depth.
- Latency: the stop-bit strobe occurs in cycle N. byte_done is in cycle N+1, the FIFO write in N+2, and ev_valid is high in N+2 when the FIFO was empty.
- Outputs: registered.

Test Plan:
1. Single frame: send 0x1C with parity=0 and stop=1. Required: ev_valid=1 at stop-strobe+2, ev_code=0x1C, ev_break=0, ev_ext=0. With ev_ready=1 for one cycle, fifo_count returns 0.
2. Prefixes:
   - Send 0xF0 then 0x1C → exactly one event: 0x1C, break=1, ext=0.
   - Send 0xE0, 0xF0, 0x75 → one event: 0x75, break=1, ext=1.
   - Send 0x1C afterwards → break=0, ext=0 (flags cleared).
3. Errors:
   - Send 0x1C with parity=1 → one parity_err pulse, no event.
   - Send 0xF0, then 0x1C with stop=0 → one frame_err pulse, no event. A following good 0x1C yields break=0.
4. Overflow: hold ev_ready=0 and send 9 distinct good codes with FIFO_AW=3. Required: fifo_count=8 and a single overflow pulse on the 9th. Draining returns the first 8 codes in order. A push and pop in the same cycle while full keeps fifo_count=8.
5. Timeout: send a start bit plus 4 data bits, then idle for TIMEOUT_CYCLES. Required: frame_err pulse at count TIMEOUT_CYCLES-1. A subsequent good 0x32 frame yields event 0x32.
6. Robustness:
   - A PS2_CLK low glitch of FILTER_LEN-3 cycles produces no strobe and no state change.
   - Asserting reset mid-frame gives outputs 0 in the next cycle, and no error or event.
